mac_dot_seq: RTL and testbench

Sequencer that drives a signed 8x8 multiply-accumulate datapath to compute one dot product per job. A job starts with a start pulse and a length. The block accepts that many operand pairs over a valid/ready stream and accumulates their products into a wrapping signed accumulator. It returns the result on a valid/ready output port with a sticky overflow flag. It sits between a vector-fetch front end and the result consumer, and owns the MAC's operand registers and accumulator.

---
 rtl/mac_dot_seq.sv | 112 +++++++++++
 tb/tb_mac_dot_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer around a signed DATA_W x DATA_W multiply-accumulate.
// Operand pairs stream in, products accumulate one cycle later, result leaves on a valid/ready port.
module mac_dot_seq #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int LEN_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    output logic                     busy,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  z,
    output logic                     ovf
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t                     state;
    logic [LEN_W-1:0]           count;
    logic signed [DATA_W-1:0]   a_reg;
    logic signed [DATA_W-1:0]   b_reg;
    logic                       p_valid;
    logic signed [ACC_W-1:0]    acc;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    addend;
    logic signed [ACC_W-1:0]    sum;
    logic                       sum_ovf;

    always_comb begin
        prod    = a_reg * b_reg;
        addend  = ACC_W'(prod);
        sum     = acc + addend;
        sum_ovf = (acc[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    end

    assign z = acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            p_valid   <= 1'b0;
            acc       <= '0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            // Product stage: the pair registered on the previous edge lands in acc now.
            if (p_valid) begin
                acc <= sum;
                if (sum_ovf) ovf <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        acc  <= '0;
                        ovf  <= 1'b0;
                        busy <= 1'b1;
                        if (len != '0) begin
                            state    <= ACCUM;
                            count    <= len;
                            in_ready <= 1'b1;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        p_valid <= 1'b1;
                        count   <= count - LEN_W'(1);
                        if (count == LEN_W'(1)) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end else begin
                        p_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    p_valid   <= 1'b0;
                    state     <= DONE;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq: job-level arithmetic model plus cycle-accurate handshake checks.
module tb_mac_dot_seq;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        len;
    logic              busy;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] a;
    logic signed [7:0] b;
    logic              out_valid;
    logic              out_ready;
    logic signed [15:0] z;
    logic              ovf;

    int n_vec = 0;
    int n_err = 0;

    int pa [8];
    int pb [8];
    int exp_z   = 0;
    bit exp_ovf = 1'b0;

    always #5 clk = ~clk;

    mac_dot_seq #(.DATA_W(8), .ACC_W(16), .LEN_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .z(z), .ovf(ovf)
    );

    task automatic check(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Dot product over pa/pb with a 16-bit wrapping accumulator; ovf if any true partial sum leaves the signed range.
    task automatic model_job(input int n, output int mz, output bit mo);
        int acc = 0;
        int v;
        logic signed [15:0] t;
        mo = 1'b0;
        for (int i = 0; i < n; i++) begin
            v = acc + pa[i] * pb[i];
            if (v > 32767 || v < -32768) mo = 1'b1;
            t = v[15:0];
            acc = int'(t);
        end
        mz = acc;
    endtask

    // Every cycle a result is presented it must match the model and the ports must be mutually consistent.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            check("z_vs_model", int'(z), exp_z);
            check("ovf_vs_model", int'(ovf), int'(exp_ovf));
            check("in_ready_low_in_done", int'(in_ready), 0);
            check("busy_in_done", int'(busy), 1);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int n);
        start = 1'b1;
        len   = 8'(n);
        tick();
        start = 1'b0;
        len   = 8'd0;
    endtask

    task automatic send(input int i);
        in_valid = 1'b1;
        a = 8'(pa[i]);
        b = 8'(pb[i]);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        if (!out_valid) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic set_pairs(input int a0, b0, a1, b1, a2, b2);
        pa[0] = a0; pb[0] = b0;
        pa[1] = a1; pb[1] = b1;
        pa[2] = a2; pb[2] = b2;
    endtask

    int mz;
    bit mo;

    initial begin
        reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        a = '0; b = '0; out_ready = 1'b1;

        // Pin the model with hand-computed values.
        set_pairs(2, 3, -4, 5, 7, 7);
        model_job(3, mz, mo);
        check("model_basic", mz, 35);
        set_pairs(127, 127, 127, 127, 127, 127);
        model_job(3, mz, mo);
        check("model_wrap_z", mz, -17149);
        check("model_wrap_ovf", int'(mo), 1);
        set_pairs(-128, -128, 0, 0, 0, 0);
        model_job(1, mz, mo);
        check("model_neg_sq_z", mz, 16384);
        check("model_neg_sq_ovf", int'(mo), 0);
        set_pairs(10, 10, -3, 2, 0, 0);
        model_job(2, mz, mo);
        check("model_bubble", mz, 94);

        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_z", int'(z), 0);
        check("rst_ovf", int'(ovf), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Basic job with exact latency and a one-cycle result.
        set_pairs(2, 3, -4, 5, 7, 7);
        model_job(3, exp_z, exp_ovf);
        start_job(3);
        check("t1_busy_after_start", int'(busy), 1);
        check("t1_in_ready", int'(in_ready), 1);
        send(0); send(1);
        check("t1_in_ready_mid", int'(in_ready), 1);
        send(2);
        check("t1_in_ready_drain", int'(in_ready), 0);
        check("t1_out_valid_early", int'(out_valid), 0);
        tick();
        check("t1_out_valid", int'(out_valid), 1);
        check("t1_z", int'(z), 35);
        tick();
        check("t1_out_valid_drop", int'(out_valid), 0);
        check("t1_busy_drop", int'(busy), 0);
        check("t1_z_hold", int'(z), 35);

        // Overflow wrap, then a job whose largest product is exactly representable.
        set_pairs(127, 127, 127, 127, 127, 127);
        model_job(3, exp_z, exp_ovf);
        start_job(3);
        send(0); send(1); send(2);
        wait_done("t2a");
        check("t2_z", int'(z), -17149);
        check("t2_ovf", int'(ovf), 1);
        tick();
        set_pairs(-128, -128, 0, 0, 0, 0);
        model_job(1, exp_z, exp_ovf);
        start_job(1);
        check("t2b_ovf_cleared", int'(ovf), 0);
        send(0);
        wait_done("t2b");
        check("t2b_z", int'(z), 16384);
        check("t2b_ovf", int'(ovf), 0);
        tick();

        // Input bubbles: in_ready stays up until the last handshake.
        set_pairs(10, 10, -3, 2, 0, 0);
        model_job(2, exp_z, exp_ovf);
        start_job(2);
        send(0);
        check("t3_ready_after_1", int'(in_ready), 1);
        tick();
        check("t3_ready_bubble1", int'(in_ready), 1);
        tick();
        check("t3_ready_bubble2", int'(in_ready), 1);
        send(1);
        check("t3_ready_after_2", int'(in_ready), 0);
        wait_done("t3");
        check("t3_z", int'(z), 94);
        tick();

        // Output backpressure with a start pulse that must be ignored.
        set_pairs(2, 3, -4, 5, 7, 7);
        model_job(3, exp_z, exp_ovf);
        out_ready = 1'b0;
        start_job(3);
        send(0); send(1); send(2);
        wait_done("t4");
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start = 1'b1;
                len = 8'd0;
            end
            tick();
            start = 1'b0;
            check("t4_hold_valid", int'(out_valid), 1);
            check("t4_hold_z", int'(z), 35);
        end
        out_ready = 1'b1;
        tick();
        check("t4_released", int'(out_valid), 0);
        check("t4_idle", int'(busy), 0);
        pa[0] = 1; pb[0] = 1;
        model_job(1, exp_z, exp_ovf);
        start_job(1);
        check("t4_restart_busy", int'(busy), 1);
        check("t4_restart_ready", int'(in_ready), 1);
        send(0);
        wait_done("t4b");
        check("t4b_z", int'(z), 1);
        tick();

        // Zero length: straight to DONE with a cleared result.
        exp_z = 0; exp_ovf = 1'b0;
        start_job(0);
        check("t5_out_valid", int'(out_valid), 1);
        check("t5_z", int'(z), 0);
        check("t5_in_ready", int'(in_ready), 0);
        tick();
        check("t5_idle", int'(busy), 0);

        // Reset mid-job aborts asynchronously.
        set_pairs(3, 4, 5, 6, 7, 8);
        start_job(4);
        send(0); send(1);
        #2 reset = 1'b1;
        #1;
        check("t6_busy", int'(busy), 0);
        check("t6_in_ready", int'(in_ready), 0);
        check("t6_out_valid", int'(out_valid), 0);
        check("t6_z", int'(z), 0);
        check("t6_ovf", int'(ovf), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        pa[0] = 5; pb[0] = -6;
        model_job(1, exp_z, exp_ovf);
        start_job(1);
        send(0);
        wait_done("t6b");
        check("t6b_z", int'(z), -30);
        tick();
        check("t6b_idle", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
